pb_keystream_mailbox: RTL and testbench

Parametrised I/O hub between two KCPSM3 cores: a producer (keystream generator) and a consumer (cipher engine).
- Replaces hand-wired port_id multiplexing with a decoded, registered port map.
- Provides a keystream FIFO, status/count registers, a hardware XOR cipher register, consumer scratch RAM and a threshold interrupt.
- Sits between both cores' port buses; each core sees only its own port_id/out_port/in_port/strobes.

---
 rtl/pb_keystream_mailbox_if.sv | 36 +++
 rtl/pb_keystream_mailbox.sv | 134 +++++++++++++
 tb/tb_pb_keystream_mailbox.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pb_keystream_mailbox_if.sv
// Port bus bundle for the keystream mailbox: producer and consumer
// KCPSM3 port_id/out_port/in_port/strobes plus consumer interrupt.
// master: the two cores' side; slave: the mailbox hub.
interface pb_keystream_mailbox_if #(
    parameter int DATA_W = 8
);
    logic [7:0]        p_port_id;
    logic [DATA_W-1:0] p_out_port;
    logic              p_write_strobe;
    logic              p_read_strobe;
    logic [DATA_W-1:0] p_in_port;

    logic [7:0]        c_port_id;
    logic [DATA_W-1:0] c_out_port;
    logic              c_write_strobe;
    logic              c_read_strobe;
    logic [DATA_W-1:0] c_in_port;
    logic              c_interrupt;
    logic              c_interrupt_ack;

    modport master (
        output p_port_id, p_out_port, p_write_strobe, p_read_strobe,
        input  p_in_port,
        output c_port_id, c_out_port, c_write_strobe, c_read_strobe,
        output c_interrupt_ack,
        input  c_in_port, c_interrupt
    );

    modport slave (
        input  p_port_id, p_out_port, p_write_strobe, p_read_strobe,
        output p_in_port,
        input  c_port_id, c_out_port, c_write_strobe, c_read_strobe,
        input  c_interrupt_ack,
        output c_in_port, c_interrupt
    );
endinterface

// File: rtl/pb_keystream_mailbox.sv
// I/O hub between a keystream producer core and a cipher consumer core.
// Ports: clk, reset (sync, active-high), bus (slave side of the port bus).
module pb_keystream_mailbox #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int RAM_AW     = 4,
    parameter int IRQ_LEVEL  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    pb_keystream_mailbox_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LEVEL_C = CW'(IRQ_LEVEL);
    localparam logic [7:0] STATUS_ADDR = 8'h40;
    localparam logic [7:0] COUNT_ADDR  = 8'h41;
    localparam logic [7:0] FIFO_ADDR   = 8'h80;
    localparam logic [7:0] CIPHER_ADDR = 8'hC0;

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] ram [2**RAM_AW];

    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count, count_next;
    logic              overflow, underflow, irq;
    logic [DATA_W-1:0] cipher_reg;
    logic [DATA_W-1:0] p_in_q, c_in_q;
    logic [DATA_W-1:0] p_rd_data, c_rd_data;
    logic [DATA_W-1:0] status, count_ext, head;

    logic empty, full;
    logic push_req, pop_req, cipher_wr, ram_sel;
    logic do_push, do_pop;
    logic ovf_set, unf_set, ovf_clr, unf_clr, crossing;
    logic unused_ok;

    assign unused_ok = bus.p_read_strobe;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);
    assign head  = empty ? '0 : fifo_mem[rd_ptr];

    assign push_req  = bus.p_write_strobe && (bus.p_port_id == FIFO_ADDR);
    assign cipher_wr = bus.c_write_strobe && (bus.c_port_id == CIPHER_ADDR);
    assign pop_req   = cipher_wr ||
                       (bus.c_read_strobe && (bus.c_port_id == FIFO_ADDR));
    assign ram_sel   = (bus.c_port_id[7:RAM_AW] == '0);

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_pop  = pop_req && !empty;
    assign do_push = push_req && (!full || do_pop);
    assign ovf_set = push_req && !do_push;
    assign unf_set = pop_req && empty;

    assign ovf_clr = (bus.p_write_strobe && bus.p_port_id == STATUS_ADDR
                      && bus.p_out_port[2]) ||
                     (bus.c_write_strobe && bus.c_port_id == STATUS_ADDR
                      && bus.c_out_port[2]);
    assign unf_clr = (bus.p_write_strobe && bus.p_port_id == STATUS_ADDR
                      && bus.p_out_port[3]) ||
                     (bus.c_write_strobe && bus.c_port_id == STATUS_ADDR
                      && bus.c_out_port[3]);

    assign count_next = count + CW'(do_push) - CW'(do_pop);
    assign crossing   = (count < LEVEL_C) && (count_next >= LEVEL_C);

    always_comb begin
        status      = '0;
        status[3:0] = {underflow, overflow, full, empty};
    end

    assign count_ext = DATA_W'(count);

    always_comb begin
        p_rd_data = '0;
        unique case (1'b1)
            bus.p_port_id == STATUS_ADDR: p_rd_data = status;
            bus.p_port_id == COUNT_ADDR:  p_rd_data = count_ext;
            default: ;
        endcase
    end

    always_comb begin
        c_rd_data = '0;
        unique case (1'b1)
            bus.c_port_id == STATUS_ADDR: c_rd_data = status;
            bus.c_port_id == COUNT_ADDR:  c_rd_data = count_ext;
            bus.c_port_id == FIFO_ADDR:   c_rd_data = head;
            bus.c_port_id == CIPHER_ADDR: c_rd_data = cipher_reg;
            ram_sel: c_rd_data = ram[bus.c_port_id[RAM_AW-1:0]];
            default: ;
        endcase
    end

    // Storage arrays carry no reset; pointers/count define validity.
    always_ff @(posedge clk) begin
        if (!reset && do_push)
            fifo_mem[wr_ptr] <= bus.p_out_port;
        if (!reset && bus.c_write_strobe && ram_sel)
            ram[bus.c_port_id[RAM_AW-1:0]] <= bus.c_out_port;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            irq        <= 1'b0;
            cipher_reg <= '0;
            p_in_q     <= '0;
            c_in_q     <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            // Sticky set outranks a same-cycle write-1-to-clear.
            overflow  <= ovf_set || (overflow && !ovf_clr);
            underflow <= unf_set || (underflow && !unf_clr);
            irq <= crossing || (irq && !bus.c_interrupt_ack);
            if (cipher_wr)
                cipher_reg <= bus.c_out_port ^ head;
            p_in_q <= p_rd_data;
            c_in_q <= c_rd_data;
        end
    end

    assign bus.p_in_port   = p_in_q;
    assign bus.c_in_port   = c_in_q;
    assign bus.c_interrupt = irq;
endmodule

// File: tb/tb_pb_keystream_mailbox.sv
// Randomised scoreboard bench for pb_keystream_mailbox against a
// queue-based reference model of the mailbox port map.
module tb_pb_keystream_mailbox;
    localparam int DEPTH = 16;
    localparam int LEVEL = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pb_keystream_mailbox_if #(.DATA_W(8)) bus ();

    pb_keystream_mailbox #(
        .DATA_W(8), .FIFO_DEPTH(DEPTH), .RAM_AW(4), .IRQ_LEVEL(LEVEL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         side;
        string      name;
        logic [7:0] port;
        logic       irq;
    } exp_t;

    exp_t sb[$];
    logic probe = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0] mq[$];
    bit         m_ovf, m_unf, m_irq;
    logic [7:0] m_cipher;
    logic [7:0] m_ram [16];
    bit         m_ram_ok [16];

    function automatic logic [7:0] m_status();
        return {4'h0, m_unf, m_ovf, mq.size() == DEPTH, mq.size() == 0};
    endfunction

    function automatic logic [7:0] m_p_read(input logic [7:0] id);
        if (id == 8'h40) return m_status();
        if (id == 8'h41) return 8'(mq.size());
        return 8'h00;
    endfunction

    function automatic logic [7:0] m_c_read(input logic [7:0] id);
        if (id == 8'h40) return m_status();
        if (id == 8'h41) return 8'(mq.size());
        if (id == 8'h80) return (mq.size() > 0) ? mq[0] : 8'h00;
        if (id == 8'hC0) return m_cipher;
        if (id < 8'h10)  return m_ram[id[3:0]];
        return 8'h00;
    endfunction

    // Drive one bus cycle, apply it to the model, queue the expectation.
    task automatic step(
        input logic [7:0] pid, input logic [7:0] pdat,
        input logic pwe, input logic pre,
        input logic [7:0] cid, input logic [7:0] cdat,
        input logic cwe, input logic cre,
        input logic ack, input logic rst,
        input int side, input string name
    );
        exp_t e;
        int   old;
        bit   pop;
        @(negedge clk);
        bus.p_port_id = pid;  bus.p_out_port = pdat;
        bus.p_write_strobe = pwe;  bus.p_read_strobe = pre;
        bus.c_port_id = cid;  bus.c_out_port = cdat;
        bus.c_write_strobe = cwe;  bus.c_read_strobe = cre;
        bus.c_interrupt_ack = ack;
        reset = rst;
        e.side = side;
        e.name = name;
        if (side == 2 && cid < 8'h10 && !m_ram_ok[cid[3:0]])
            e.side = 0;
        e.port = rst ? 8'h00 : (side == 1 ? m_p_read(pid) : m_c_read(cid));
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; m_irq = 0;
            m_cipher = 8'h00;
        end else begin
            old = mq.size();
            pop = (cre && cid == 8'h80) || (cwe && cid == 8'hC0);
            if (cwe && cid == 8'hC0)
                m_cipher = (mq.size() > 0) ? (cdat ^ mq[0]) : cdat;
            if (pwe && pid == 8'h40) begin
                if (pdat[2]) m_ovf = 0;
                if (pdat[3]) m_unf = 0;
            end
            if (cwe && cid == 8'h40) begin
                if (cdat[2]) m_ovf = 0;
                if (cdat[3]) m_unf = 0;
            end
            if (pop) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else m_unf = 1;
            end
            if (pwe && pid == 8'h80) begin
                if (mq.size() < DEPTH) mq.push_back(pdat);
                else m_ovf = 1;
            end
            if (cwe && cid < 8'h10) begin
                m_ram[cid[3:0]] = cdat;
                m_ram_ok[cid[3:0]] = 1;
            end
            if (old < LEVEL && mq.size() >= LEVEL) m_irq = 1;
            else if (ack) m_irq = 0;
        end
        e.irq = m_irq;
        sb.push_back(e);
        probe = 1'b1;
    endtask

    task automatic idle(input string name);
        step(8'hFF, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 0, 0, name);
    endtask
    task automatic p_push(input logic [7:0] d);
        step(8'h80, d, 1, 0, 8'hFF, 0, 0, 0, 0, 0, 0, "push");
    endtask
    task automatic p_wr(input logic [7:0] id, input logic [7:0] d);
        step(id, d, 1, 0, 8'hFF, 0, 0, 0, 0, 0, 0, "p_wr");
    endtask
    task automatic p_rd(input logic [7:0] id, input string name);
        step(id, 0, 0, 1, 8'hFF, 0, 0, 0, 0, 0, 1, name);
    endtask
    task automatic c_wr(input logic [7:0] id, input logic [7:0] d);
        step(8'hFF, 0, 0, 0, id, d, 1, 0, 0, 0, 0, "c_wr");
    endtask
    task automatic c_rd(input logic [7:0] id, input string name);
        step(8'hFF, 0, 0, 0, id, 0, 0, 1, 0, 0, 2, name);
    endtask
    task automatic push_pop(input logic [7:0] d);
        step(8'h80, d, 1, 0, 8'h80, 0, 0, 1, 0, 0, 2, "push_pop");
    endtask
    task automatic ack();
        step(8'hFF, 0, 0, 0, 8'hFF, 0, 0, 0, 1, 0, 0, "ack");
    endtask
    task automatic do_reset();
        step(8'h80, 8'hEE, 1, 0, 8'h80, 0, 0, 1, 0, 1, 1, "reset");
    endtask

    always @(posedge clk) begin
        if (probe) begin
            exp_t e;
            #2;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_underrun: no expectation queued");
            end else begin
                e = sb.pop_front();
                vectors++;
                if (bus.c_interrupt !== e.irq) begin
                    miscompares++;
                    $display("FAIL %s irq: got %b want %b",
                             e.name, bus.c_interrupt, e.irq);
                end
                if (e.side == 1) begin
                    vectors++;
                    if (bus.p_in_port !== e.port) begin
                        miscompares++;
                        $display("FAIL %s p_in_port: got %02h want %02h",
                                 e.name, bus.p_in_port, e.port);
                    end
                end else if (e.side == 2) begin
                    vectors++;
                    if (bus.c_in_port !== e.port) begin
                        miscompares++;
                        $display("FAIL %s c_in_port: got %02h want %02h",
                                 e.name, bus.c_in_port, e.port);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] ids_c [8];
        logic [7:0] ids_p [5];
        ids_c = '{8'h40, 8'h41, 8'h80, 8'hC0, 8'h03, 8'h0F, 8'h55, 8'h07};
        ids_p = '{8'h40, 8'h41, 8'h80, 8'h03, 8'hFF};
        for (int i = 0; i < 16; i++) m_ram_ok[i] = 0;

        do_reset();
        p_rd(8'h40, "status_after_reset");
        p_rd(8'h41, "count_after_reset");

        p_push(8'hA5);
        p_push(8'h3C);
        c_wr(8'hC0, 8'h48);
        c_rd(8'hC0, "cipher_ed");
        c_rd(8'h80, "pop_3c");
        c_rd(8'h41, "count_zero");

        for (int i = 0; i < 17; i++) p_push(8'(i));
        p_rd(8'h40, "status_full_ovf");
        for (int i = 0; i < 17; i++) c_rd(8'h80, "drain_pop");
        c_rd(8'h40, "status_unf");
        c_wr(8'h40, 8'h0C);
        p_rd(8'h40, "status_cleared");

        ack();
        for (int i = 0; i < 4; i++) p_push(8'h10 + 8'(i));
        idle("irq_raised");
        ack();
        p_push(8'h20);
        idle("irq_no_reraise");
        c_rd(8'h80, "pop_to_4");
        c_rd(8'h80, "pop_to_3");
        p_push(8'h21);
        idle("irq_reraised");
        ack();

        while (mq.size() < DEPTH) p_push(8'($urandom));
        push_pop(8'h77);
        c_rd(8'h40, "no_ovf_on_swap");
        for (int i = 0; i < 16; i++) c_rd(8'h80, "wrap_pop");

        c_wr(8'h03, 8'h5A);
        c_wr(8'h0F, 8'h11);
        c_rd(8'h03, "ram_03");
        c_rd(8'h0F, "ram_0f");
        p_rd(8'h03, "p_ram_unmapped");
        for (int i = 0; i < 5; i++) p_push(8'h30 + 8'(i));
        do_reset();
        c_rd(8'h41, "count_after_midreset");
        c_rd(8'h03, "ram_kept");

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 11))
                0, 1, 2: p_push(8'($urandom));
                3, 4:    c_rd(8'h80, "rnd_pop");
                5:       c_wr(8'hC0, 8'($urandom));
                6:       c_rd(ids_c[$urandom_range(0, 7)], "rnd_c_rd");
                7:       p_rd(ids_p[$urandom_range(0, 4)], "rnd_p_rd");
                8:       c_wr(8'($urandom_range(0, 15)), 8'($urandom));
                9:       if ($urandom_range(0, 1) == 1)
                             p_wr(8'h40, 8'($urandom));
                         else
                             c_wr(8'h40, 8'($urandom));
                10:      if ($urandom_range(0, 3) == 0) ack();
                         else push_pop(8'($urandom));
                default: if ($urandom_range(0, 20) == 0) do_reset();
                         else idle("rnd_idle");
            endcase
        end

        @(negedge clk);
        probe = 1'b0;
        bus.p_write_strobe = 0; bus.p_read_strobe = 0;
        bus.c_write_strobe = 0; bus.c_read_strobe = 0;
        bus.c_interrupt_ack = 0;
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
